// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader connects through the master modport; the byte source and memory use slave.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [5:0]  im_waddr;
  logic [31:0] im_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words, writes them
// to instruction memory and holds the core in reset until a full image has arrived.
module imem_loader #(
  parameter int IM_DEPTH = 64,
  parameter int TIMEOUT  = 1024
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                load_start,
  imem_loader_if.master       bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                load_done,
  output logic                load_error,
  output logic [6:0]          words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [1:0]    byte_idx;
  logic [5:0]    word_idx;
  logic [TW-1:0] tmo_cnt;
  logic          started;
  logic [31:0]   wdata;
  logic          xfer;
  logic          last_word;

  assign xfer      = bus.rx_valid && (state == S_RECV);
  assign last_word = (word_idx == 6'(IM_DEPTH - 1));

  // NOTE: every output is decoded from registers only, so an asynchronous reset
  // forces them to their idle values at once, with no clock edge needed.
  assign bus.rx_ready = (state == S_RECV);
  assign bus.im_we    = (state == S_WRITE);
  assign bus.im_waddr = word_idx;
  assign bus.im_wdata = wdata;
  assign cpu_reset    = (state != S_DONE);
  assign busy         = (state == S_RECV) || (state == S_WRITE);
  assign load_done    = (state == S_DONE);
  assign load_error   = (state == S_ERROR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      byte_idx     <= '0;
      word_idx     <= '0;
      words_loaded <= '0;
      tmo_cnt      <= '0;
      started      <= 1'b0;
      wdata        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            state        <= S_RECV;
            byte_idx     <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
            tmo_cnt      <= '0;
            started      <= 1'b0;
            wdata        <= '0;
          end
        end
        S_RECV: begin
          if (xfer) begin
            wdata[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            tmo_cnt  <= '0;
            started  <= 1'b1;
            if (byte_idx == 2'd3) state <= S_WRITE;
          end else if (started) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            // The partial word is dropped here so it can never reach memory.
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              state    <= S_ERROR;
              byte_idx <= '0;
              wdata    <= '0;
            end
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + 7'd1;
          if (last_word) begin
            state <= S_DONE;
          end else begin
            word_idx <= word_idx + 6'd1;
            state    <= S_RECV;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: full, gapped, timeout, reset-abort and start-handling loads.
module tb_imem_loader;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       load_start;
  logic       cpu_reset;
  logic       busy;
  logic       load_done;
  logic       load_error;
  logic [6:0] words_loaded;

  int n_checks = 0;
  int n_err    = 0;
  int we_count = 0;

  imem_loader_if bus ();

  imem_loader #(.IM_DEPTH(64), .TIMEOUT(1024)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .load_start   (load_start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) if (bus.im_we === 1'b1) we_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge CLOCK_50);
    load_start = 1'b0;
  endtask

  // Presents one byte until it is accepted (bounded), then idles for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic taken;
    taken = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = (bus.rx_ready === 1'b1);
      @(negedge CLOCK_50);
    end
    bus.rx_valid = 1'b0;
    check("byte_accepted", {31'd0, taken}, 32'd1);
    repeat (gap) @(negedge CLOCK_50);
  endtask

  // Sends a word LSB first and checks the write strobe the cycle after its 4th byte.
  task automatic send_word(input logic [31:0] w, input int addr, input int gap);
    for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8], gap);
    send_byte(w[31:24], 0);
    check("we_after_4th", {31'd0, bus.im_we}, 32'd1);
    check("waddr", {26'd0, bus.im_waddr}, addr);
    check("wdata", bus.im_wdata, w);
    repeat (gap) @(negedge CLOCK_50);
  endtask

  function automatic logic [31:0] ramp_word(input int w);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4*w);
    b1 = 8'(4*w + 1);
    b2 = 8'(4*w + 2);
    b3 = 8'(4*w + 3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    int base;
    logic seen_ready;
    reset        = 1'b0;
    load_start   = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset values before any clock edge.
    #1;
    check("rst_rx_ready",   {31'd0, bus.rx_ready}, 32'd0);
    check("rst_im_we",      {31'd0, bus.im_we},    32'd0);
    check("rst_busy",       {31'd0, busy},         32'd0);
    check("rst_done",       {31'd0, load_done},    32'd0);
    check("rst_error",      {31'd0, load_error},   32'd0);
    check("rst_waddr",      {26'd0, bus.im_waddr}, 32'd0);
    check("rst_wdata",      bus.im_wdata,          32'd0);
    check("rst_words",      {25'd0, words_loaded}, 32'd0);
    check("rst_cpu_reset",  {31'd0, cpu_reset},    32'd1);

    @(negedge CLOCK_50);
    reset = 1'b1;

    // Valid bytes offered in IDLE are never taken.
    seen_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      if (bus.rx_ready !== 1'b0 || bus.im_we !== 1'b0) seen_ready = 1'b1;
    end
    bus.rx_valid = 1'b0;
    check("idle_no_ready_no_we", {31'd0, seen_ready}, 32'd0);
    check("idle_we_count", we_count, 32'd0);
    check("idle_words", {25'd0, words_loaded}, 32'd0);

    // Full back-to-back load.
    pulse_start();
    check("load1_busy", {31'd0, busy}, 32'd1);
    check("load1_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    base = we_count;
    for (int w = 0; w < 64; w++) send_word(ramp_word(w), w, 0);
    @(negedge CLOCK_50);
    check("load1_done", {31'd0, load_done}, 32'd1);
    check("load1_cpu_reset_low", {31'd0, cpu_reset}, 32'd0);
    check("load1_words", {25'd0, words_loaded}, 32'd64);
    check("load1_busy_low", {31'd0, busy}, 32'd0);
    check("load1_we_count", we_count - base, 32'd64);

    // Reload from DONE with 3 idle cycles between bytes; a start pulse mid-load is ignored.
    pulse_start();
    check("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("reload_busy", {31'd0, busy}, 32'd1);
    check("reload_words", {25'd0, words_loaded}, 32'd0);
    check("reload_done_low", {31'd0, load_done}, 32'd0);
    base = we_count;
    for (int w = 0; w < 5; w++) send_word(ramp_word(w), w, 3);
    pulse_start();
    check("recv_start_ignored_words", {25'd0, words_loaded}, 32'd5);
    check("recv_start_ignored_busy", {31'd0, busy}, 32'd1);
    for (int w = 5; w < 64; w++) send_word(ramp_word(w), w, 3);
    check("load2_done", {31'd0, load_done}, 32'd1);
    check("load2_words", {25'd0, words_loaded}, 32'd64);
    check("load2_we_count", we_count - base, 32'd64);

    // Timeout: no timeout before the first byte; after the 5th byte, 1024 idle cycles abort.
    pulse_start();
    repeat (1100) @(negedge CLOCK_50);
    check("pre_first_byte_busy", {31'd0, busy}, 32'd1);
    check("pre_first_byte_no_error", {31'd0, load_error}, 32'd0);
    base = we_count;
    send_word(32'hDEADBEEF, 0, 0);
    send_byte(8'h11, 0);
    repeat (1023) @(negedge CLOCK_50);
    check("tmo_1023_no_error", {31'd0, load_error}, 32'd0);
    check("tmo_1023_busy", {31'd0, busy}, 32'd1);
    @(negedge CLOCK_50);
    check("tmo_error", {31'd0, load_error}, 32'd1);
    check("tmo_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("tmo_words", {25'd0, words_loaded}, 32'd1);
    check("tmo_busy_low", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge CLOCK_50);
    check("tmo_we_count", we_count - base, 32'd1);

    // Reset in the middle of word 10, applied between clock edges.
    pulse_start();
    for (int w = 0; w < 10; w++) send_word(ramp_word(w), w, 0);
    send_byte(8'h28, 0);
    send_byte(8'h29, 0);
    base = we_count;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("mid_rst_im_we", {31'd0, bus.im_we}, 32'd0);
    check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("mid_rst_words", {25'd0, words_loaded}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    bus.rx_data  = 8'h2A;
    bus.rx_valid = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check("mid_rst_no_we", we_count - base, 32'd0);
    pulse_start();
    send_word(32'hDDCCBBAA, 0, 0);
    @(negedge CLOCK_50);
    check("after_rst_words", {25'd0, words_loaded}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter IM_DEPTH, default 64, meaning the number of 32-bit instruction words per load, which is also the instruction-memory word depth.
REQ-002 The module SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of idle RECV cycles allowed once the first byte of a load has been accepted.
REQ-003 CLOCK_50  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 load_start  in  1  single-cycle request to begin a program load.
REQ-006 rx_data  in  8  incoming program byte.
REQ-007 rx_valid  in  1  rx_data is valid.
REQ-008 rx_ready  out  1  loader accepts a byte this cycle.
REQ-009 im_we  out  1  instruction-memory write enable.
REQ-010 im_waddr  out  6  instruction-memory word address (matches the byte-address bits [7:2] used by the fetch port).
REQ-011 im_wdata  out  32  assembled instruction word.
REQ-012 cpu_reset  out  1  active-high reset driven to the processor core.
REQ-013 busy  out  1  high while in RECV or WRITE.
REQ-014 load_done  out  1  a complete load has finished.
REQ-015 load_error  out  1  the load was aborted by timeout.
REQ-016 words_loaded  out  7  count of words written in the current load (0..64).

Function
REQ-017 The state machine SHALL have exactly the states IDLE, RECV, WRITE, DONE and ERROR.
REQ-018 A byte transfer SHALL occur only in a cycle where rx_valid=1 and rx_ready=1.
REQ-019 rx_ready SHALL be 1 only in RECV.
REQ-020 In IDLE, DONE and ERROR, a load_start=1 SHALL cause the next state to be RECV and SHALL clear the byte index, word index, words_loaded, the timeout counter, load_done and load_error.
REQ-021 In RECV and WRITE, load_start SHALL be ignored.
REQ-022 Bytes SHALL be assembled little-endian: byte k (k=0..3) of a word goes to im_wdata[8k+7:8k].
REQ-023 The transfer of the 4th byte of a word SHALL move the state to WRITE.
REQ-024 im_we SHALL be asserted for exactly one cycle, in WRITE, which is the cycle immediately after the 4th-byte transfer.
REQ-025 During that WRITE cycle, im_waddr SHALL equal the word index and im_wdata SHALL be the full assembled word.
REQ-026 On leaving WRITE, the word index and words_loaded SHALL increment; if the written address was IM_DEPTH-1 the next state SHALL be DONE, otherwise RECV.
REQ-027 im_waddr SHALL never wrap within a load.
REQ-028 Timeout counter behaviour:
  - counts only in RECV, and only after the first byte of the load has been accepted;
  - clears on every transfer;
  - when it reaches TIMEOUT, the next state SHALL be ERROR.
REQ-029 A partially assembled word SHALL be discarded on entry to ERROR and SHALL NOT be written.
REQ-030 cpu_reset SHALL be 0 only in DONE and 1 in all other states.
REQ-031 A reload from DONE SHALL reassert cpu_reset on the cycle RECV is entered.
REQ-032 load_done SHALL be 1 exactly in DONE.
REQ-033 load_error SHALL be 1 exactly in ERROR.
REQ-034 busy SHALL be 1 exactly in RECV and WRITE.
REQ-035 If rx_valid=1 while not in RECV, the byte SHALL NOT be consumed and no state SHALL change.

Reset
REQ-036 While reset=0, the following SHALL apply immediately, without waiting for a clock edge:
  - state is IDLE;
  - rx_ready=0, im_we=0, busy=0, load_done=0, load_error=0;
  - im_waddr=0, im_wdata=0, words_loaded=0;
  - cpu_reset=1.
REQ-037 Reset asserted mid-load SHALL abort the load with no further im_we pulse.
REQ-038 The next load after a mid-load reset SHALL start at im_waddr=0.

Verification
REQ-039 Full load: load_start, then 256 bytes with byte i = i mod 256 -> im_we writes 0x03020100 at address 0 and 0xFFFEFDFC at address 63; then load_done=1, cpu_reset=0, words_loaded=64.
REQ-040 Gapped stream: 3 idle cycles between every byte -> identical memory contents; exactly one im_we per word, one cycle after its 4th byte.
REQ-041 Timeout: 5 bytes, then rx_valid=0 for 1024 cycles -> load_error=1, cpu_reset=1, words_loaded=1, and no write occurs for the partial word.
REQ-042 Mid-load reset: reset=0 after 2 bytes of word 10 -> rx_ready=0, im_we=0, cpu_reset=1, words_loaded=0 with no clock edge required; the next load writes word 0 to address 0.
REQ-043 Start handling:
  - load_start pulsed during RECV -> ignored, no counter clears;
  - load_start pulsed in DONE -> cpu_reset=1 and busy=1 the next cycle, words_loaded=0.
REQ-044 Idle input: rx_valid=1 in IDLE for 10 cycles -> rx_ready stays 0 and no im_we occurs.
